if_prefetch: RTL

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch_pkg.sv | 23 ++
 rtl/if_prefetch_if.sv | 28 ++
 rtl/if_prefetch_sync_fifo.sv | 49 ++++
 rtl/if_prefetch.sv | 94 +++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared widths, buffer entry layout and fetch-state encoding for the
// instruction prefetch unit.
package if_prefetch_pkg;

  localparam int XLEN    = 64;
  localparam int ILEN    = 32;
  localparam int ENTRY_W = XLEN + ILEN;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  // IDLE: nothing outstanding; BUSY: response will be kept; DROP: response will be discarded.
  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_BUSY,
    FETCH_DROP
  } fetch_state_e;

endpackage

// File: rtl/if_prefetch_if.sv
// Memory request/response, decode-side handshake and redirect signals of the
// prefetch unit; master is the prefetch unit, slave is its environment.
interface if_prefetch_if;
  import if_prefetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_valid;
  logic [ILEN-1:0] imem_rdata;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic [3:0]      buf_count;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr, buf_count,
    input  imem_valid, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, buf_count,
    output imem_valid, imem_rdata, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/if_prefetch_sync_fifo.sv
// Synchronous FIFO with flush; push while full (without pop) and pop while
// empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !flush && (count != '0);
  assign do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // NOTE: storage is not reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: keeps at most one memory read outstanding, buffers
// responses in a FIFO and presents the head to decode; redirect flushes.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  if_prefetch_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_addr;
  logic [CW-1:0]   count;
  entry_t          head;
  entry_t          tail_entry;
  logic            req;
  logic            push;
  logic            pop;
  logic            has_entry;

  assign has_entry  = (count != '0);
  assign pop        = has_entry && !bus.stall && !bus.redirect;
  assign tail_entry = '{pc: req_addr, instr: bus.imem_rdata};

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    push       = 1'b0;
    unique case (state)
      FETCH_IDLE: begin
        if (!reset && !bus.redirect && (32'(count) < DEPTH)) begin
          req        = 1'b1;
          state_next = FETCH_BUSY;
        end
      end
      FETCH_BUSY: begin
        if (bus.imem_valid) begin
          push       = !bus.redirect;
          state_next = FETCH_IDLE;
        end else if (bus.redirect) begin
          state_next = FETCH_DROP;
        end
      end
      FETCH_DROP: begin
        if (bus.imem_valid) state_next = FETCH_IDLE;
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH_IDLE;
      pc       <= RESET_PC;
      req_addr <= '0;
    end else begin
      state <= state_next;
      if (bus.redirect) pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (req)     pc <= pc + 64'd4;
      if (req) req_addr <= pc;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.redirect),
    .push  (push),
    .pop   (pop),
    .wdata (tail_entry),
    .rdata (head),
    .count (count)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = has_entry;
  assign bus.if_pc     = has_entry ? head.pc : '0;
  assign bus.if_instr  = has_entry ? head.instr : NOP_INSTR;
  assign bus.buf_count = 4'(count);

endmodule
